// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and grant-pointer encoding for the write-back port arbiter.
package wb_port_arbiter_pkg;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RD_W     = $clog2(NUM_REGS);

   typedef enum logic {
      PRI_ALU = 1'b0,
      PRI_LD  = 1'b1
   } pri_e;

endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; requester 0 is favoured out of reset.
module rr_arb2
   import wb_port_arbiter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_ptr
);

   pri_e r_state;
   pri_e w_state_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= PRI_ALU;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A lone requester always wins; on a tie the pointer decides.
   always_comb begin
      o_gnt0      = 1'b0;
      o_gnt1      = 1'b0;
      w_state_nxt = r_state;
      if (i_req0 && (!i_req1 || r_state == PRI_ALU)) begin
         o_gnt0      = 1'b1;
         w_state_nxt = PRI_LD;
      end else if (i_req1) begin
         o_gnt1      = 1'b1;
         w_state_nxt = PRI_ALU;
      end
   end

   assign o_ptr = (r_state == PRI_LD);

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: shares the register write port between ALU and load,
// and registers CPSR/PC updates so every architectural write is a 1-cycle pulse.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REGS = wb_port_arbiter_pkg::NUM_REGS,
   parameter int unsigned DATA_W   = wb_port_arbiter_pkg::DATA_W,
   localparam int unsigned RW      = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   input  logic [RW-1:0]     alu_rd,
   input  logic [DATA_W-1:0] alu_result,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [RW-1:0]     ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              cmp_valid,
   input  logic [DATA_W-1:0] cmp_cpsr,
   input  logic              jmp_valid,
   input  logic [DATA_W-1:0] jmp_target,
   output logic              reg_write_en,
   output logic [RW-1:0]     reg_num,
   output logic [DATA_W-1:0] reg_value,
   output logic              cpsr_write_en,
   output logic [DATA_W-1:0] cpsr_out,
   output logic              pc_write_en,
   output logic [DATA_W-1:0] pc_out,
   output logic              pri_ld
);

   logic w_alu_gnt;
   logic w_ld_gnt;

   logic              r_reg_write_en;
   logic [RW-1:0]     r_reg_num;
   logic [DATA_W-1:0] r_reg_value;
   logic              r_cpsr_write_en;
   logic [DATA_W-1:0] r_cpsr_out;
   logic              r_pc_write_en;
   logic [DATA_W-1:0] r_pc_out;

   rr_arb2 u_arb (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_req0  (alu_valid),
      .i_req1  (ld_valid),
      .o_gnt0  (w_alu_gnt),
      .o_gnt1  (w_ld_gnt),
      .o_ptr   (pri_ld)
   );

   assign alu_ready = w_alu_gnt;
   assign ld_ready  = w_ld_gnt;

   // Data registers only load on acceptance so they hold between strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reg_write_en  <= 1'b0;
         r_reg_num       <= '0;
         r_reg_value     <= '0;
         r_cpsr_write_en <= 1'b0;
         r_cpsr_out      <= '0;
         r_pc_write_en   <= 1'b0;
         r_pc_out        <= '0;
      end else begin
         r_reg_write_en  <= w_alu_gnt | w_ld_gnt;
         r_cpsr_write_en <= cmp_valid;
         r_pc_write_en   <= jmp_valid;
         if (w_alu_gnt) begin
            r_reg_num   <= alu_rd;
            r_reg_value <= alu_result;
         end else if (w_ld_gnt) begin
            r_reg_num   <= ld_rd;
            r_reg_value <= ld_data;
         end
         if (cmp_valid) r_cpsr_out <= cmp_cpsr;
         if (jmp_valid) r_pc_out   <= jmp_target;
      end
   end

   assign reg_write_en  = r_reg_write_en;
   assign reg_num       = r_reg_num;
   assign reg_value     = r_reg_value;
   assign cpsr_write_en = r_cpsr_write_en;
   assign cpsr_out      = r_cpsr_out;
   assign pc_write_en   = r_pc_write_en;
   assign pc_out        = r_pc_out;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter and sequencer between the execute/memory stages and the architectural state (register file, CPSR, PC). It shares the single register-file write port between the ALU result path and the load-return path using round-robin grant with valid/ready handshakes. It also registers CPSR (compare) and PC (jump) updates so that every architectural write leaves on a one-cycle enable pulse, one cycle after acceptance.

## Interface
- `NUM_REGS`, 16: register-file depth; `rd` width is log2(`NUM_REGS`) = 4.
- `DATA_W`, 32: data, CPSR and PC width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result available.
- `alu_rd` in 4: ALU destination register.
- `alu_result` in 32: ALU result.
- `alu_ready` out 1: ALU request accepted this cycle.
- `ld_valid` in 1: load data available.
- `ld_rd` in 4: load destination register.
- `ld_data` in 32: loaded value.
- `ld_ready` out 1: load request accepted this cycle.
- `cmp_valid` in 1: compare flags available.
- `cmp_cpsr` in 32: new CPSR.
- `jmp_valid` in 1: branch target available.
- `jmp_target` in 32: new PC.
- `reg_write_en` out 1: register-file write strobe.
- `reg_num` out 4: register-file write address.
- `reg_value` out 32: register-file write data.
- `cpsr_write_en` out 1: CPSR write strobe.
- `cpsr_out` out 32: CPSR write data.
- `pc_write_en` out 1: PC write strobe.
- `pc_out` out 32: PC write data.
- `pri_ld` out 1: current round-robin pointer (0 means ALU favoured); debug.

## Operation
- Register port grant FSM has two states:
  - PRI_ALU is the reset state; ALU wins ties.
  - PRI_LD: load wins ties.
- Grant rules:
  - Only one valid requester: it is granted regardless of state.
  - Both valid: the favoured requester is granted.
  - Neither valid: no grant, and the state holds.
- After any grant, the state moves to favour the other requester (grant ALU → PRI_LD; grant LD → PRI_ALU).
- `alu_ready` and `ld_ready` are combinational from the valids and the state, and are mutually exclusive.
- `alu_ready` and `ld_ready` never assert without the matching valid.
- A requester that is not granted must hold valid and payload stable; it is guaranteed a grant on the next cycle.
- CMP and JMP have no ready signal. They are always accepted, on dedicated ports independent of the register port.
- CMP and JMP may be accepted in the same cycle as each other and as a register grant.
- A register write to r15 is an ordinary register write. If a JMP is accepted in the same cycle, both outputs fire and the PC port owner resolves the conflict; this block never drops a write.
- The same `rd` requested by ALU and LD in one cycle: only the granted request is written. The other is written the next cycle, so the later write wins.

## Timing
- Latency: a request accepted in cycle N drives its outputs in cycle N+1 only.
- Each `*_write_en` is a one-cycle pulse per accepted request.
- Back-to-back grants give one write per cycle with no bubbles.
- All outputs are registered.
- Reset values: all `*_write_en` = 0; `reg_num` = 0; `reg_value`, `cpsr_out`, `pc_out` = 0; `pri_ld` = 0 (PRI_ALU).
- Data outputs hold their last value when the enable is low.
- Reset asserted mid-operation: on the next cycle every enable is 0, even if the reset hits in the cycle after an acceptance; that pending write is lost. The FSM returns to PRI_ALU.
- After `reset_n` deasserts, the first cycle follows normal grant rules.

## Structure
- Shared include header holds:
  - `DATA_W` and the register-number width.
  - FSM state encodings: PRI_ALU = 1'b0, PRI_LD = 1'b1.
- Natural sub-module: `rr_arb2`, a two-requester round-robin arbiter with a pointer flop, reusable for the memory port.
- The top level instantiates `rr_arb2` and holds the output register stage.

## Test plan
- Reset then idle: hold `reset_n` low 3 cycles, all valids 0 → every output 0, `pri_ld` = 0.
- ALU only: `alu_valid` = 1, `alu_rd` = 3, `alu_result` = 0x12345678 → `alu_ready` = 1 the same cycle; next cycle `reg_write_en` = 1, `reg_num` = 3, `reg_value` = 0x12345678 for exactly one cycle.
- Contention: ALU (rd 1, 0xA) and LD (rd 2, 0xB) both valid for 2 cycles from reset:
  - cycle 0: ALU granted.
  - cycle 1: LD granted.
  - outputs: writes r1 = 0xA, then r2 = 0xB, on consecutive cycles.
- Same `rd`: ALU (rd 5, 0x1) and LD (rd 5, 0x2) contend in PRI_LD → LD granted first, ALU next; r5 ends at 0x1.
- Simultaneous CMP + JMP + LD: `cmp_cpsr` = 0x80000000, `jmp_target` = 0x100, LD rd 4 = 0x55 → next cycle all three strobes high with matching data.
- Reset mid-flight: accept ALU, assert `reset_n` low before the next edge → `reg_write_en` stays 0 and `pri_ld` = 0.
